m_imem_writer: RTL
==================

Name: m_imem_writer

Overview:
- Instruction encoder and loader: the write side of the 64-word instruction memory that the processor fetches from.
- Accepts instruction field tuples over a valid/ready handshake and encodes each one into a 32-bit RV32 word.
- The immediate packing is the exact inverse of the team's immediate generator, so encode followed by decode round-trips.
- Writes encoded words to sequential word addresses, then asserts done so the core can be released from hold.

Parameters:
- DEPTH, 64, number of instruction words; write address width is log2(DEPTH) = 6.

Ports:
- w_clk  in  1  clock; all state updates on the rising edge.
- w_rst  in  1  synchronous, active-high reset.
- w_valid  in  1  input tuple valid.
- w_ready  out  1  block can accept a tuple this cycle.
- w_type  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- w_opcode  in  7  opcode bits [6:0].
- w_funct3  in  3  funct3.
- w_funct7  in  7  funct7; used for R-type only.
- w_rd, w_rs1, w_rs2  in  5 each  register fields.
- w_imm  in  32  immediate; units per type, see Behaviour.
- w_last  in  1  this tuple is the final instruction.
- w_we  out  1  imem write strobe.
- w_waddr  out  6  imem word address.
- w_wdata  out  32  encoded instruction.
- w_count  out  7  number of words written, 0..64.
- w_done  out  1  load complete; core may run.
- w_err  out  1  sticky error: a tuple was rejected.

Behaviour:
- Clock and reset: single clock w_clk; w_rst is synchronous, active-high.
- Reset values:
  - state = LOAD.
  - w_we = 0, w_waddr = 0, w_wdata = 0, w_count = 0, w_done = 0, w_err = 0.
  - Any pending write is dropped.
- States:
  - LOAD: w_ready = 1 while w_count < DEPTH.
  - DONE: w_ready = 0, w_done = 1; held until w_rst.
- Handshake:
  - A transfer occurs on a rising edge with w_valid & w_ready.
  - Fields are sampled only on transfer cycles.
  - w_ready does not depend combinationally on w_valid.
- Latency: a tuple accepted at edge N produces w_we = 1 with w_waddr / w_wdata valid for exactly the cycle following edge N; write pulses last one cycle.
- Throughput: one tuple per cycle.
- w_count increments on the edge where the write is registered, and w_waddr = w_count[5:0] at that edge.
- Encoding (rd = ir[11:7], rs1 = ir[19:15], rs2 = ir[24:20], funct3 = ir[14:12], opcode = ir[6:0]):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; w_imm is ignored.
  - I: ir[31:20] = imm[11:0]; fields rs1, funct3, rd.
  - S: ir[31:25] = imm[11:5], ir[11:7] = imm[4:0]; fields rs2, rs1, funct3.
  - B: w_imm is a halfword offset. ir[31] = imm[11], ir[7] = imm[10], ir[30:25] = imm[9:4], ir[11:8] = imm[3:0]; fields rs2, rs1, funct3.
  - U: ir[31:12] = imm[31:12]; field rd.
  - J: w_imm is a byte offset. ir[31] = imm[20], ir[30:21] = imm[10:1], ir[20] = imm[11], ir[19:12] = imm[19:12]; field rd.
- Range checks; any failure rejects the tuple:
  - I, S, B: imm[31:11] must be all 0s or all 1s.
  - U: imm[11:0] must be 0.
  - J: imm[0] must be 0, and imm[31:20] must be all 0s or all 1s.
  - w_type of 6 or 7 is illegal.
- On a rejected tuple:
  - No write; w_count and address unchanged.
  - w_err is set the next cycle and stays set until reset.
  - If w_last was set, still move to DONE.
- Completion:
  - On the edge that registers the 64th write (w_count becomes 64), state goes to DONE.
  - A transfer with w_last = 1 moves state to DONE on its transfer edge; its write, if legal, still occurs in the next cycle.
  - w_done rises in the same cycle as that final w_we.
- Full boundary: w_ready drops in the cycle w_count reaches 64; no address wrap-around.
- Reset mid-operation: a write pending from the previous edge is suppressed; w_we = 0 in the cycle after reset is sampled.

Test Plan:
- I-type: type=1, opcode=0x13, rd=1, rs1=0, imm=3 -> next cycle w_we=1, w_waddr=0, w_wdata=0x00300093; w_count=1.
- R-type add x5,x1,x2: opcode=0x33, funct3=0, funct7=0 -> w_wdata=0x002082B3. Then S-type sw x2,-4(x1) (opcode 0x23, funct3 2) -> 0xFE20AE23.
- Round-trip: random legal tuples of every type through the team's immediate generator -> decoded imm == w_imm for I/S/U/J; for B, decoded value == w_imm (halfword units).
- Errors:
  - I with imm=2048 -> no w_we, w_err=1, w_count unchanged.
  - U with imm=0x00001001 -> rejected.
  - Next legal tuple -> written at the same address.
- Completion and full:
  - 3 tuples with w_last on the 3rd -> w_done=1 with the 3rd write (w_waddr=2), then w_ready=0.
  - 64 back-to-back valid tuples with no w_last -> addresses 0..63, w_done at 64, no further writes.
- Reset mid-stream: accept a tuple and assert w_rst on the next edge -> no w_we, w_count=0, w_err=0, state LOAD with w_ready=1.

Source files
------------

// File: rtl/m_imem_writer.sv
// rtl/m_imem_writer.sv - RV32 instruction encoder and sequential loader for the 64-word imem
module m_imem_writer #(
    parameter int DEPTH = 64
) (
    input  logic                       w_clk,
    input  logic                       w_rst,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [2:0]                 w_type,
    input  logic [6:0]                 w_opcode,
    input  logic [2:0]                 w_funct3,
    input  logic [6:0]                 w_funct7,
    input  logic [4:0]                 w_rd,
    input  logic [4:0]                 w_rs1,
    input  logic [4:0]                 w_rs2,
    input  logic [31:0]                w_imm,
    input  logic                       w_last,
    output logic                       w_we,
    output logic [$clog2(DEPTH)-1:0]   w_waddr,
    output logic [31:0]                w_wdata,
    output logic [$clog2(DEPTH):0]     w_count,
    output logic                       w_done,
    output logic                       w_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t          state_q;
    logic            we_q;
    logic [AW-1:0]   waddr_q;
    logic [31:0]     wdata_q;
    logic [AW:0]     count_q;
    logic            err_q;

    logic [31:0]     enc_d;
    logic            legal_d;
    logic            sx11_ok;
    logic            sx20_ok;
    logic            xfer;

    // Immediates that must fit a sign-extended 12-bit / 21-bit field.
    assign sx11_ok = (w_imm[31:11] == '0) || (w_imm[31:11] == '1);
    assign sx20_ok = (w_imm[31:20] == '0) || (w_imm[31:20] == '1);

    always_comb begin
        enc_d   = '0;
        legal_d = 1'b0;
        case (w_type)
            3'd0: begin
                enc_d   = {w_funct7, w_rs2, w_rs1, w_funct3, w_rd, w_opcode};
                legal_d = 1'b1;
            end
            3'd1: begin
                enc_d   = {w_imm[11:0], w_rs1, w_funct3, w_rd, w_opcode};
                legal_d = sx11_ok;
            end
            3'd2: begin
                enc_d   = {w_imm[11:5], w_rs2, w_rs1, w_funct3, w_imm[4:0], w_opcode};
                legal_d = sx11_ok;
            end
            3'd3: begin
                // Branch offset arrives in halfwords, so every bit sits one lower than the byte form.
                enc_d   = {w_imm[11], w_imm[9:4], w_rs2, w_rs1, w_funct3,
                           w_imm[3:0], w_imm[10], w_opcode};
                legal_d = sx11_ok;
            end
            3'd4: begin
                enc_d   = {w_imm[31:12], w_rd, w_opcode};
                legal_d = (w_imm[11:0] == '0);
            end
            3'd5: begin
                enc_d   = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], w_rd, w_opcode};
                legal_d = ~w_imm[0] & sx20_ok;
            end
            default: begin
                enc_d   = '0;
                legal_d = 1'b0;
            end
        endcase
    end

    assign w_ready = (state_q == S_LOAD) && (count_q < (AW+1)'(DEPTH));
    assign xfer    = w_valid & w_ready;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q <= S_LOAD;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (xfer) begin
                if (legal_d) begin
                    we_q    <= 1'b1;
                    waddr_q <= count_q[AW-1:0];
                    wdata_q <= enc_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == (AW+1)'(DEPTH - 1)) begin
                        state_q <= S_DONE;
                    end
                end else begin
                    err_q <= 1'b1;
                end
                if (w_last) begin
                    state_q <= S_DONE;
                end
            end
        end
    end

    assign w_we    = we_q;
    assign w_waddr = waddr_q;
    assign w_wdata = wdata_q;
    assign w_count = count_q;
    assign w_done  = (state_q == S_DONE);
    assign w_err   = err_q;
endmodule
